output_serializer: RTL

- Parametrised successor to the fixed 32-bit to 9-bit output stage.
- Accepts one IN_W-bit result word per transaction over a valid/ready handshake and emits it as ceil(IN_W/OUT_W) beats of OUT_W bits, least-significant chunk first.
- Sits between the matrix-multiply result path and the narrow output pins.
- Supports back-pressure, a last-beat marker, back-to-back words without bubbles, and synchronous flush.

---
 rtl/output_serializer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/output_serializer.sv
// output_serializer: splits one IN_W-bit result word into ceil(IN_W/OUT_W) beats of OUT_W bits,
// least-significant chunk first. It uses a valid/ready handshake on both sides, marks the last
// beat, sends back-to-back words without bubbles and supports a synchronous flush.
// Optional build macro: OSER_BYPASS_EN presents beat 0 combinationally from in_data while idle,
// giving zero latency on the first beat.
module output_serializer #(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned OUT_W     = 9,
  localparam int unsigned NUM_BEATS = (IN_W + OUT_W - 1) / OUT_W,
  localparam int unsigned BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [BEAT_W-1:0] out_beat
);

  localparam int unsigned       BUF_W    = NUM_BEATS * OUT_W;
  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(NUM_BEATS - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e              r_state;
  logic [BUF_W-1:0]    r_buf;
  logic [BEAT_W-1:0]   r_cnt;

  state_e              w_state_nxt;
  logic [BUF_W-1:0]    w_buf_nxt;
  logic [BEAT_W-1:0]   w_cnt_nxt;
  logic [BUF_W-1:0]    w_ext;
  logic                w_last;
  logic                w_accept;
  logic                w_xfer;

  assign w_last   = (r_cnt == LastBeat);
  assign in_ready = !flush && ((r_state == StIdle) ||
                               ((r_state == StSend) && out_ready && w_last));
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = out_valid && out_ready;

  // Zero-extend the incoming word so the final beat is padded with zeros above IN_W-1.
  always_comb begin
    w_ext             = '0;
    w_ext[IN_W-1:0]   = in_data;
  end

  // Present the current beat from the held word; optionally bypass beat 0 while idle.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_beat  = '0;
    out_last  = 1'b0;
    if (r_state == StSend) begin
      out_valid = 1'b1;
      out_data  = OUT_W'(r_buf >> (32'(r_cnt) * OUT_W));
      out_beat  = r_cnt;
      out_last  = w_last;
    end
`ifdef OSER_BYPASS_EN
    else if (in_valid && !flush) begin
      out_valid = 1'b1;
      out_data  = in_data[OUT_W-1:0];
      out_last  = (NUM_BEATS == 1);
    end
`endif
  end

  // Next-state logic: load on accept, step through beats, reload on last beat, flush to idle.
  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            w_buf_nxt   = w_ext;
            w_cnt_nxt   = '0;
            w_state_nxt = StSend;
`ifdef OSER_BYPASS_EN
            // Beat 0 already left through the bypass path this cycle.
            if (out_ready) begin
              if (NUM_BEATS == 1) begin
                w_state_nxt = StIdle;
              end else begin
                w_cnt_nxt = BEAT_W'(1);
              end
            end
`endif
          end
        end
        StSend: begin
          if (w_xfer) begin
            if (!w_last) begin
              w_cnt_nxt = r_cnt + 1'b1;
            end else if (w_accept) begin
              // Back-to-back: next word starts right after the last beat, no bubble.
              w_buf_nxt = w_ext;
              w_cnt_nxt = '0;
            end else begin
              w_state_nxt = StIdle;
              w_cnt_nxt   = '0;
            end
          end
        end
        default: begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, word buffer and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_buf   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
